// File: rtl/t10_tick_scheduler.sv
// t10_tick_scheduler: round-robin shared interval counter with one-cycle completion pulses
module t10_tick_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      elapsed
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, g, win, g_next, cand;
    logic [WIDTH-1:0] count, max;
    logic [NREQ-1:0] sel;

    // first requester at or after ptr, wrapping around
    always_comb begin
        win  = ptr;
        cand = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            cand = IW'(j);
            if (req[cand]) win = cand;
        end
    end

    assign g_next = (g == IW'(NREQ - 1)) ? '0 : g + IW'(1);
    assign sel    = NREQ'(1) << g;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state: a dropped request in COUNT beats reaching the limit
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = |req ? COUNT : IDLE;
            COUNT:   state_nxt = !req[g] ? IDLE : (count == max) ? DONE : COUNT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // winner, limit, counter and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            g     <= '0;
            count <= '0;
            max   <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    g     <= win;
                    max   <= len[win*WIDTH +: WIDTH];
                    count <= '0;
                end
                COUNT: begin
                    if (!req[g])            ptr   <= g_next;
                    else if (count == max)  count <= '0;
                    else                    count <= count + WIDTH'(1);
                end
                DONE: ptr <= g_next;
                default: ;
            endcase
        end
    end

    assign grant   = (state == IDLE)  ? '0 : sel;
    assign done    = (state == DONE)  ? sel : '0;
    assign busy    = (state != IDLE);
    assign elapsed = (state == COUNT) ? count : '0;
endmodule

// File: tb/tb_t10_tick_scheduler.sv
// tb_t10_tick_scheduler: directed checks of arbitration, interval timing, cancel and reset
module tb_t10_tick_scheduler;
    localparam int NREQ  = 4;
    localparam int WIDTH = 30;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] len = '0;
    logic [NREQ-1:0]       grant, done;
    logic                  busy;
    logic [WIDTH-1:0]      elapsed;
    int checks = 0;
    int errors = 0;

    t10_tick_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req(req), .len(len),
        .grant(grant), .done(done), .busy(busy), .elapsed(elapsed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int v);
        len[i*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    initial begin
        int order[5];
        int order2[3];
        step(2);
        rst = 1'b0;
        step(1);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_elapsed", elapsed, 0);
        check("rst_done", done, 0);

        // reset aborts mid-count
        set_len(0, 10);
        req = 4'b0001;
        step(1);
        check("acc_grant", grant, 4'b0001);
        check("acc_busy", busy, 1);
        step(3);
        check("mid_elapsed", elapsed, 3);
        #2 rst = 1'b1;
        #1;
        check("arst_grant", grant, 0);
        check("arst_busy", busy, 0);
        check("arst_elapsed", elapsed, 0);
        req = '0;
        #1 rst = 1'b0;
        step(2);
        check("post_rst_busy", busy, 0);
        check("post_rst_elapsed", elapsed, 0);

        // single request, len 5
        set_len(0, 5);
        req = 4'b0001;
        step(1);
        for (int c = 0; c <= 5; c++) begin
            check("single_grant", grant, 4'b0001);
            check("single_elapsed", elapsed, c);
            check("single_nodone", done, 0);
            step(1);
        end
        check("single_done", done, 4'b0001);
        check("single_done_grant", grant, 4'b0001);
        check("single_done_elapsed", elapsed, 0);
        req = '0;
        step(1);
        check("single_idle_grant", grant, 0);
        check("single_idle_done", done, 0);

        // zero length, held request gives a 3-cycle period (ptr=1 here)
        set_len(2, 0);
        req = 4'b0100;
        step(1);
        check("zero_grant", grant, 4'b0100);
        check("zero_nodone", done, 0);
        step(1);
        check("zero_done", done, 4'b0100);
        step(1);
        check("zero_idle", busy, 0);
        step(1);
        check("zero_regrant", grant, 4'b0100);
        step(1);
        check("zero_redone", done, 4'b0100);
        req = '0;
        step(1);
        check("zero_end_idle", busy, 0);

        // round robin from ptr 0 with all requesting
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_len(i, 2);
        req = 4'b1111;
        order = '{0, 1, 2, 3, 0};
        foreach (order[n]) begin
            step(1);
            check("rr_grant", grant, 4'b0001 << order[n]);
            step(3);
            check("rr_done", done, 4'b0001 << order[n]);
            step(1);
            check("rr_idle", busy, 0);
        end
        req = 4'b1101;
        order2 = '{2, 3, 0};
        foreach (order2[n]) begin
            step(1);
            check("rr2_grant", grant, 4'b0001 << order2[n]);
            step(3);
            check("rr2_done", done, 4'b0001 << order2[n]);
            if (n == 2) req = '0;
            step(1);
            check("rr2_idle", busy, 0);
        end

        // cancel at elapsed 7 (ptr=1 here)
        set_len(1, 20);
        req = 4'b0010;
        step(1);
        check("cancel_grant", grant, 4'b0010);
        step(7);
        check("cancel_elapsed", elapsed, 7);
        req = '0;
        step(1);
        check("cancel_grant_low", grant, 0);
        check("cancel_busy_low", busy, 0);
        check("cancel_nodone", done, 0);
        set_len(0, 3);
        set_len(3, 3);
        req = 4'b1011;
        step(1);
        check("cancel_next_from2", grant, 4'b1000);
        req = '0;
        step(1);
        check("cancel2_idle", busy, 0);

        // cancel coinciding with count==max (ptr=0 here)
        set_len(0, 2);
        req = 4'b0001;
        step(1);
        step(2);
        check("tie_elapsed", elapsed, 2);
        req = '0;
        step(1);
        check("tie_nodone", done, 0);
        check("tie_grant", grant, 0);

        // len change during COUNT is ignored
        set_len(3, 4);
        req = 4'b1000;
        step(1);
        set_len(3, 100);
        for (int c = 0; c <= 4; c++) begin
            check("late_elapsed", elapsed, c);
            check("late_nodone", done, 0);
            step(1);
        end
        check("late_done", done, 4'b1000);
        req = '0;
        step(1);
        check("late_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
